seq_pattern_serial_gen: RTL and testbench

//  Serial pattern transmitter; the source side of the serial 1011 detector link.
//  On a start request it shifts a fixed PAT_W-bit pattern out MSB-first, one bit per clk.

---
 rtl/seq_pattern_serial_gen.sv | 151 +++++++++++++++
 tb/tb_seq_pattern_serial_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_serial_gen.sv
// Serial pattern transmitter: shifts PATTERN out MSB-first for a programmable number of frames.
// Optional inter-frame idle gap enabled by defining SEQGEN_GAP_EN.
module seq_pattern_serial_gen #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1011),
  parameter int unsigned      CNT_W   = 4,
  parameter int unsigned      GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_rep_cnt,
  input  logic             i_abort,
  output logic             o_seq,
  output logic             o_valid,
  output logic             o_frame_start,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned BIT_W = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b11;
`ifdef SEQGEN_GAP_EN
  localparam logic [1:0] ST_GAP   = 2'b10;
  localparam int unsigned GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);
`endif

  logic [1:0]       state, state_nxt;
  logic [PAT_W-1:0] sreg, sreg_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [CNT_W-1:0] rep, rep_nxt;
  logic             seq_nxt, valid_nxt, fs_nxt, busy_nxt, done_nxt;
`ifdef SEQGEN_GAP_EN
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
`endif

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      sreg          <= '0;
      bit_cnt       <= '0;
      rep           <= '0;
      o_seq         <= 1'b0;
      o_valid       <= 1'b0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
`ifdef SEQGEN_GAP_EN
      gap_cnt       <= '0;
`endif
    end else begin
      state         <= state_nxt;
      sreg          <= sreg_nxt;
      bit_cnt       <= bit_cnt_nxt;
      rep           <= rep_nxt;
      o_seq         <= seq_nxt;
      o_valid       <= valid_nxt;
      o_frame_start <= fs_nxt;
      o_busy        <= busy_nxt;
      o_done        <= done_nxt;
`ifdef SEQGEN_GAP_EN
      gap_cnt       <= gap_cnt_nxt;
`endif
    end
  end

  // Next-state and next-output logic; outputs reflect the current state one edge later
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_cnt_nxt = bit_cnt;
    rep_nxt     = rep;
    seq_nxt     = 1'b0;
    valid_nxt   = 1'b0;
    fs_nxt      = 1'b0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
`ifdef SEQGEN_GAP_EN
    gap_cnt_nxt = gap_cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          rep_nxt     = (i_rep_cnt == '0) ? CNT_W'(1) : i_rep_cnt;
          sreg_nxt    = PATTERN;
          bit_cnt_nxt = '0;
          state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        seq_nxt     = sreg[PAT_W-1];
        valid_nxt   = 1'b1;
        busy_nxt    = 1'b1;
        fs_nxt      = (bit_cnt == '0);
        sreg_nxt    = {sreg[PAT_W-2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + BIT_W'(1);
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_nxt = '0;
          rep_nxt     = rep - CNT_W'(1);
          if (rep > CNT_W'(1)) begin
            sreg_nxt = PATTERN;
`ifdef SEQGEN_GAP_EN
            gap_cnt_nxt = '0;
            state_nxt   = ST_GAP;
`else
            state_nxt   = ST_SHIFT;
`endif
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
`ifdef SEQGEN_GAP_EN
      ST_GAP: begin
        busy_nxt = 1'b1;
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_SHIFT;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
`endif
      ST_DONE: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a start request seen in IDLE
    if (i_abort) begin
      state_nxt = ST_IDLE;
      seq_nxt   = 1'b0;
      valid_nxt = 1'b0;
      fs_nxt    = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_pattern_serial_gen.sv
// Bench for seq_pattern_serial_gen: directed vector table, hand sequences and random
// stimulus checked against a queue-based schedule of expected output cycles.
module tb_seq_pattern_serial_gen;

  localparam int unsigned GAP_LEN = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [3:0] i_rep_cnt = 4'd0;
  logic       i_abort = 1'b0;
  logic       o_seq, o_valid, o_frame_start, o_busy, o_done;

  seq_pattern_serial_gen #(
    .PAT_W(4), .PATTERN(4'b1011), .CNT_W(4), .GAP_LEN(GAP_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_rep_cnt(i_rep_cnt),
    .i_abort(i_abort), .o_seq(o_seq), .o_valid(o_valid),
    .o_frame_start(o_frame_start), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {seq, valid, frame_start, busy, done}
  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic [3:0] rep;
    logic       abort;
    logic [4:0] exp;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [4:0] sched[$];
  logic [3:0] pat = 4'b1011;

  int cnt_valid, cnt_fs, cnt_done, max_run, cur_run;
  logic [31:0] bits;

  // Schedule the cycle-by-cycle output sequence of one accepted transfer
  function automatic void schedule(input logic [3:0] rc);
    int frames;
    frames = (rc == 4'd0) ? 1 : int'(rc);
    for (int f = 0; f < frames; f++) begin
      for (int b = 0; b < 4; b++)
        sched.push_back({pat[3-b], 1'b1, (b == 0), 1'b1, 1'b0});
`ifdef SEQGEN_GAP_EN
      if (f != frames - 1)
        for (int g = 0; g < int'(GAP_LEN); g++) sched.push_back(5'b00010);
`endif
    end
    sched.push_back(5'b00011);
  endfunction

  // Apply one cycle of inputs and advance the reference schedule
  task automatic drive(input logic r, input logic s, input logic [3:0] rc,
                       input logic a, output logic [4:0] mexp);
    @(negedge clk);
    rst_n = r; i_start = s; i_rep_cnt = rc; i_abort = a;
    @(posedge clk);
    if (!r || a) begin
      sched.delete();
      mexp = 5'b0;
    end else if (sched.size() == 0) begin
      mexp = 5'b0;
      if (s) schedule(rc);
    end else begin
      mexp = sched.pop_front();
    end
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {o_seq, o_valid, o_frame_start, o_busy, o_done};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got {seq,valid,fs,busy,done}=%b expected %b at %0t", name, got, exp, $time);
    end
    if (o_valid) begin
      cnt_valid++; bits = {bits[30:0], o_seq}; cur_run++;
      if (cur_run > max_run) max_run = cur_run;
    end else cur_run = 0;
    if (o_frame_start) cnt_fs++;
    if (o_done) cnt_done++;
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_tally();
    cnt_valid = 0; cnt_fs = 0; cnt_done = 0; bits = '0; max_run = 0; cur_run = 0;
  endtask

  task automatic step(input string name, input logic r, input logic s,
                      input logic [3:0] rc, input logic a);
    logic [4:0] m;
    drive(r, s, rc, a, m);
    check(name, m);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) step(name, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] m;
    // Reset with start held, single frame, start+abort in IDLE, zero repeat count
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, 4'd1, 1'b0, 5'b00000});
    tbl.push_back('{1'b1, 1'b1, 4'd1, 1'b0, 5'b00000});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b11110});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b01010});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b11010});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b11010});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b00011});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b00000});
    tbl.push_back('{1'b1, 1'b1, 4'd1, 1'b1, 5'b00000});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b00000});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b00000});
    tbl.push_back('{1'b1, 1'b1, 4'd0, 1'b0, 5'b00000});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b11110});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b01010});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b11010});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b11010});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b00011});
    tbl.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 5'b00000});

    clear_tally();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst_n, tbl[i].start, tbl[i].rep, tbl[i].abort, m);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Three frames back-to-back
    clear_tally();
    step("rep3_start", 1'b1, 1'b1, 4'd3, 1'b0);
    idle("rep3", 15);
    check_int("rep3_valid_bits", cnt_valid, 12);
    check_int("rep3_frame_starts", cnt_fs, 3);
    check_int("rep3_done", cnt_done, 1);
    check_int("rep3_pattern", int'(bits[11:0]), 12'hBBB);

    // Abort on the second bit of the first frame, then restart
    clear_tally();
    step("abort_start", 1'b1, 1'b1, 4'd2, 1'b0);
    idle("abort_bits", 2);
    step("abort_hit", 1'b1, 1'b0, 4'd0, 1'b1);
    check_int("abort_busy_low", int'(o_busy), 0);
    step("restart", 1'b1, 1'b1, 4'd1, 1'b0);
    idle("restart_run", 6);
    check_int("abort_done_count", cnt_done, 1);
    check_int("abort_valid_bits", cnt_valid, 2 + 4);

    // Start during SHIFT is ignored
    clear_tally();
    step("busy_start", 1'b1, 1'b1, 4'd1, 1'b0);
    idle("busy_run", 2);
    step("busy_restart_req", 1'b1, 1'b1, 4'd5, 1'b0);
    idle("busy_tail", 6);
    check_int("busy_ignore_bits", cnt_valid, 4);

    // Reset in the middle of a frame
    step("midrst_start", 1'b1, 1'b1, 4'd2, 1'b0);
    idle("midrst_run", 2);
    step("midrst_hit", 1'b0, 1'b0, 4'd0, 1'b0);
    idle("midrst_after", 3);

    // Two frames: contiguous, or separated by a gap when built with the gap option
    clear_tally();
    step("rep2_start", 1'b1, 1'b1, 4'd2, 1'b0);
    idle("rep2", 14);
    check_int("rep2_valid_bits", cnt_valid, 8);
    check_int("rep2_done", cnt_done, 1);
`ifdef SEQGEN_GAP_EN
    check_int("rep2_max_run", max_run, 4);
`else
    check_int("rep2_max_run", max_run, 8);
`endif

    // Random traffic against the schedule model
    for (int i = 0; i < 3000; i++) begin
      step("random",
           ($urandom_range(0, 99) != 0),
           ($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 29) == 0));
    end
    idle("drain", 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
